// File: rtl/ide_ppi_sequencer.sv
// ide_ppi_sequencer: strobe timing controller for the 8255 PPI on the IDE/CF
// port window, with CPU wait-state generation and read data capture.
module ide_ppi_sequencer #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned RECOV_CYC  = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ppi_cs,
    input  logic [1:0] address,
    input  logic       ioread,
    input  logic       iowrite,
    input  logic [7:0] cpu_dout,
    input  logic [7:0] ppi_din,
    output logic [1:0] ppi_a,
    output logic       ppi_cs_n,
    output logic       ppi_rd_n,
    output logic       ppi_wr_n,
    output logic [7:0] ppi_dout,
    output logic       ppi_doe,
    output logic [7:0] cpu_din,
    output logic       wait_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE,
        S_RECOVER
    } state_e;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] RECOV_LD  = 4'(RECOV_CYC - 1);

    localparam bit PARAMS_OK =
        (SETUP_CYC  >= 1) && (SETUP_CYC  <= 15) &&
        (STROBE_CYC >= 1) && (STROBE_CYC <= 15) &&
        (HOLD_CYC   >= 1) && (HOLD_CYC   <= 15) &&
        (RECOV_CYC  >= 1) && (RECOV_CYC  <= 15);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       cs_q;
    logic       wr_q, wr_d;
    logic       pend_q, pend_d;
    logic [1:0] a_q, a_d;
    logic [7:0] dout_q, dout_d;
    logic [7:0] din_q, din_d;

    logic start;
    logic active;
    logic cnt_zero;

    assign start    = ppi_cs & ~cs_q & (ioread | iowrite);
    assign cnt_zero = (cnt_q == 4'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        pend_d  = pend_q;
        a_d     = a_q;
        dout_d  = dout_q;
        din_d   = din_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = address;
                    dout_d  = cpu_dout;
                    wr_d    = iowrite;
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_zero) begin
                    if (!wr_q) begin
                        din_d = ppi_din;
                    end
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (!ppi_cs) begin
                    state_d = S_RECOVER;
                    cnt_d   = RECOV_LD;
                end
            end
            S_RECOVER: begin
                // Queue an access that arrives while the 8255 recovers.
                if (start) begin
                    a_d    = address;
                    dout_d = cpu_dout;
                    wr_d   = iowrite;
                    pend_d = 1'b1;
                end
                if (cnt_zero) begin
                    if (pend_q || start) begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LD;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            // Treat the chip select as already seen so a held
            // ppi_cs does not restart an access after reset.
            cs_q    <= 1'b1;
            wr_q    <= 1'b0;
            pend_q  <= 1'b0;
            a_q     <= 2'd0;
            dout_q  <= 8'd0;
            din_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= ppi_cs;
            wr_q    <= wr_d;
            pend_q  <= pend_d;
            a_q     <= a_d;
            dout_q  <= dout_d;
            din_q   <= din_d;
        end
    end

    always_ff @(posedge clock) begin
        assert (PARAMS_OK);
    end

    assign active = (state_q == S_SETUP)
                  | (state_q == S_STROBE)
                  | (state_q == S_HOLD);

    assign ppi_cs_n = ~active;
    assign ppi_rd_n = ~((state_q == S_STROBE) & ~wr_q);
    assign ppi_wr_n = ~((state_q == S_STROBE) & wr_q);
    assign ppi_doe  = active & wr_q;
    assign ppi_a    = a_q;
    assign ppi_dout = dout_q;
    assign cpu_din  = din_q;
    assign busy     = (state_q != S_IDLE);

    assign wait_req = ((state_q == S_IDLE) & start)
                    | active
                    | pend_q
                    | ((state_q == S_RECOVER) & start);

endmodule

// File: tb/tb_ide_ppi_sequencer.sv
// Bench for ide_ppi_sequencer: directed and random accesses checked
// against a phase-length timeline model.
module tb_ide_ppi_sequencer;

    localparam int S_D = 2, P_D = 4, H_D = 2, R_D = 2;
    localparam int S_2 = 1, P_2 = 1, H_2 = 1, R_2 = 3;

    typedef struct {
        logic cs_n;
        logic rd_n;
        logic wr_n;
        logic doe;
        logic wait_req;
        logic busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs1, cs2;
    logic       ioread, iowrite;
    logic [1:0] address;
    logic [7:0] cpu_dout, ppi_din;

    logic [1:0] a1, a2;
    logic       csn1, csn2, rdn1, rdn2, wrn1, wrn2;
    logic       doe1, doe2, wt1, wt2, bz1, bz2;
    logic [7:0] do1, do2, di1, di2;

    int checks = 0;
    int errors = 0;

    logic [1:0] ma [2];
    logic [7:0] md [2];
    logic [7:0] mi [2];

    always #5 clk = ~clk;

    ide_ppi_sequencer dut (
        .clock(clk), .reset(reset), .ppi_cs(cs1),
        .address(address), .ioread(ioread), .iowrite(iowrite),
        .cpu_dout(cpu_dout), .ppi_din(ppi_din),
        .ppi_a(a1), .ppi_cs_n(csn1), .ppi_rd_n(rdn1),
        .ppi_wr_n(wrn1), .ppi_dout(do1), .ppi_doe(doe1),
        .cpu_din(di1), .wait_req(wt1), .busy(bz1)
    );

    ide_ppi_sequencer #(
        .SETUP_CYC(S_2), .STROBE_CYC(P_2),
        .HOLD_CYC(H_2), .RECOV_CYC(R_2)
    ) dut2 (
        .clock(clk), .reset(reset), .ppi_cs(cs2),
        .address(address), .ioread(ioread), .iowrite(iowrite),
        .cpu_dout(cpu_dout), .ppi_din(ppi_din),
        .ppi_a(a2), .ppi_cs_n(csn2), .ppi_rd_n(rdn2),
        .ppi_wr_n(wrn2), .ppi_dout(do2), .ppi_doe(doe2),
        .cpu_din(di2), .wait_req(wt2), .busy(bz2)
    );

    // Expected strobes k cycles after the start edge, from phase lengths.
    function automatic exp_t model(input int k, input bit act,
                                   input bit wr, input int drop,
                                   input int s, input int p,
                                   input int h, input int r);
        exp_t e;
        int t, done_last, idle_at;
        t = s + p + h;
        done_last = (drop > t + 1) ? drop : t + 1;
        idle_at = done_last + 1 + r;
        e.cs_n     = !(act && k >= 1 && k <= t);
        e.rd_n     = !(act && !wr && k > s && k <= s + p);
        e.wr_n     = !(act && wr && k > s && k <= s + p);
        e.doe      = act && wr && k >= 1 && k <= t;
        e.wait_req = act && k >= 0 && k <= t;
        e.busy     = act && k >= 1 && k < idle_at;
        return e;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.cs_n = 1'b1; e.rd_n = 1'b1; e.wr_n = 1'b1;
        e.doe = 1'b0; e.wait_req = 1'b0; e.busy = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input int k,
                       input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc %0d observed %0h expected %0h",
                   tag, k, obs, expv);
        end
    endtask

    task automatic chk_all(input int w, input int k, input exp_t e);
        if (w != 0) begin
            chk("dut2.cs_n", k, 8'(csn2), 8'(e.cs_n));
            chk("dut2.rd_n", k, 8'(rdn2), 8'(e.rd_n));
            chk("dut2.wr_n", k, 8'(wrn2), 8'(e.wr_n));
            chk("dut2.doe",  k, 8'(doe2), 8'(e.doe));
            chk("dut2.wait", k, 8'(wt2),  8'(e.wait_req));
            chk("dut2.busy", k, 8'(bz2),  8'(e.busy));
            chk("dut2.ppi_a", k, 8'(a2), 8'(ma[1]));
            chk("dut2.ppi_dout", k, do2, md[1]);
            chk("dut2.cpu_din", k, di2, mi[1]);
        end else begin
            chk("cs_n", k, 8'(csn1), 8'(e.cs_n));
            chk("rd_n", k, 8'(rdn1), 8'(e.rd_n));
            chk("wr_n", k, 8'(wrn1), 8'(e.wr_n));
            chk("doe",  k, 8'(doe1), 8'(e.doe));
            chk("wait", k, 8'(wt1),  8'(e.wait_req));
            chk("busy", k, 8'(bz1),  8'(e.busy));
            chk("ppi_a", k, 8'(a1), 8'(ma[0]));
            chk("ppi_dout", k, do1, md[0]);
            chk("cpu_din", k, di1, mi[0]);
        end
    endtask

    task automatic set_cs(input int w, input logic v);
        if (w != 0) cs2 = v;
        else cs1 = v;
    endtask

    // One access: ppi_cs high from cycle 0 until cycle drop.
    task automatic access(input int w, input bit rd, input bit wr,
                          input logic [1:0] a, input logic [7:0] d,
                          input logic [7:0] din, input int drop,
                          input int rst_at);
        int s, p, h, r, t, n;
        bit act;
        exp_t e;
        s = (w != 0) ? S_2 : S_D;
        p = (w != 0) ? P_2 : P_D;
        h = (w != 0) ? H_2 : H_D;
        r = (w != 0) ? R_2 : R_D;
        act = rd | wr;
        t = s + p + h;
        n = ((drop > t + 1) ? drop : t + 1) + 1 + r;
        for (int k = 0; k <= n; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                set_cs(w, 1'b1);
                address = a; ioread = rd; iowrite = wr; cpu_dout = d;
            end
            if (k == drop) begin
                set_cs(w, 1'b0);
                ioread = 1'b0; iowrite = 1'b0;
            end
            ppi_din = din;
            reset = (k == rst_at);
            if (k == 1 && act) begin
                ma[w] = a; md[w] = d;
            end
            if (k == s + p + 1 && act && !wr) mi[w] = din;
            if (rst_at >= 0 && k == rst_at + 1) begin
                for (int i = 0; i < 2; i++) begin
                    ma[i] = 2'd0; md[i] = 8'd0; mi[i] = 8'd0;
                end
            end
            #3;
            e = model(k, act, wr, drop, s, p, h, r);
            if (rst_at >= 0 && k > rst_at) e = idle_exp();
            chk_all(w, k, e);
            if (rst_at >= 0 && k == rst_at + 1) break;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        set_cs(w, 1'b0);
        ioread = 1'b0; iowrite = 1'b0;
    endtask

    // Read then a second access whose edge lands in RECOVER.
    task automatic b2b(input bit wr2, input logic [1:0] ax,
                       input logic [1:0] ay, input logic [7:0] dx,
                       input logic [7:0] dy, input logic [7:0] din);
        exp_t e;
        int t;
        t = S_D + P_D + H_D;
        for (int k = 0; k <= 11 + t + 1 + R_D + 1; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                cs1 = 1'b1; address = ax;
                ioread = 1'b1; iowrite = 1'b0; cpu_dout = dx;
            end
            if (k == 9) begin
                cs1 = 1'b0; ioread = 1'b0;
            end
            if (k == 10) begin
                cs1 = 1'b1; address = ay;
                ioread = !wr2; iowrite = wr2; cpu_dout = dy;
            end
            if (k == 11 + t + 1) begin
                cs1 = 1'b0; ioread = 1'b0; iowrite = 1'b0;
            end
            ppi_din = din;
            if (k == 1) begin
                ma[0] = ax; md[0] = dx;
            end
            if (k == S_D + P_D + 1) mi[0] = din;
            if (k == 11) begin
                ma[0] = ay; md[0] = dy;
            end
            if (k == 11 + S_D + P_D + 1 && !wr2) mi[0] = din;
            #3;
            if (k < 10) begin
                e = model(k, 1'b1, 1'b0, 9, S_D, P_D, H_D, R_D);
            end else if (k == 10) begin
                e = idle_exp();
                e.wait_req = 1'b1; e.busy = 1'b1;
            end else begin
                e = model(k - 11, 1'b1, wr2, t + 1, S_D, P_D, H_D, R_D);
                if (k == 11) e.busy = 1'b1;
            end
            chk_all(0, k, e);
        end
        @(posedge clk); #1;
        cs1 = 1'b0; ioread = 1'b0; iowrite = 1'b0;
    endtask

    initial begin
        int q, drop;
        reset = 1'b1;
        cs1 = 1'b0; cs2 = 1'b0;
        ioread = 1'b0; iowrite = 1'b0;
        address = 2'd0; cpu_dout = 8'd0; ppi_din = 8'd0;
        for (int i = 0; i < 2; i++) begin
            ma[i] = 2'd0; md[i] = 8'd0; mi[i] = 8'd0;
        end
        @(posedge clk);
        @(posedge clk); #4;
        chk_all(0, -1, idle_exp());
        chk_all(1, -1, idle_exp());
        @(posedge clk); #1;
        reset = 1'b0;

        access(0, 1'b1, 1'b0, 2'b01, 8'h3C, 8'hA5, 9, -1);
        access(0, 1'b0, 1'b1, 2'b11, 8'h92, 8'h00, 9, -1);
        access(0, 1'b1, 1'b0, 2'b10, 8'h11, 8'h5A, 4, -1);
        access(0, 1'b0, 1'b1, 2'b01, 8'h77, 8'hEE, 9, 4);
        access(0, 1'b0, 1'b0, 2'b10, 8'h44, 8'h99, 3, -1);
        access(0, 1'b1, 1'b1, 2'b00, 8'hC3, 8'h12, 9, -1);
        access(1, 1'b1, 1'b0, 2'b10, 8'h01, 8'h6D, 4, -1);
        b2b(1'b1, 2'b01, 2'b10, 8'h21, 8'hB4, 8'h7E);
        b2b(1'b0, 2'b11, 2'b00, 8'h0F, 8'hF0, 8'hC8);

        for (int i = 0; i < 14; i++) begin
            q = int'($urandom_range(0, 3));
            drop = int'($urandom_range(1, 12));
            access((i >= 10) ? 1 : 0, q[0], q[1],
                   2'($urandom), 8'($urandom), 8'($urandom),
                   drop, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ide_ppi_sequencer.md
Name: ide_ppi_sequencer

Overview:
- Timing controller for the 8255 PPI that fronts the IDE/CF interface at I/O ports 0x30-0x33.
- Takes the decoded 8255 port chip select plus the bus read/write qualifiers.
- Generates the 8255 CS_n/RD_n/WR_n/A1:0 strobes with programmable setup, pulse, hold and recovery times.
- Holds the CPU in wait states while an access is in flight, and latches 8255 read data for the CPU bus mux.

Parameters:
- SETUP_CYC, 2, clocks address/CS_n are stable before RD_n/WR_n falls (1-15)
- STROBE_CYC, 4, clocks RD_n/WR_n are held low (1-15)
- HOLD_CYC, 2, clocks address/CS_n/write data are held after the strobe rises (1-15)
- RECOV_CYC, 2, minimum idle clocks between consecutive 8255 accesses (1-15)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ppi_cs  in  1  8255 port-range chip select from the port decoder (level, whole bus cycle)
- address  in  2  CPU A1:A0
- ioread  in  1  sINP qualifier
- iowrite  in  1  sOUT qualifier
- cpu_dout  in  8  CPU write data
- ppi_din  in  8  data bus from the 8255
- ppi_a  out  2  8255 A1:A0
- ppi_cs_n  out  1  8255 chip select, active low
- ppi_rd_n  out  1  8255 read strobe, active low
- ppi_wr_n  out  1  8255 write strobe, active low
- ppi_dout  out  8  write data to the 8255
- ppi_doe  out  1  ppi_dout drive enable
- cpu_din  out  8  latched read data to the CPU input mux
- wait_req  out  1  CPU wait request (high = insert wait)
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - ppi_cs_n=1, ppi_rd_n=1, ppi_wr_n=1, ppi_doe=0.
  - ppi_a=0, ppi_dout=0, cpu_din=0.
  - wait_req=0, busy=0, pending=0.
  - FSM=IDLE, counter=0.
- Reset mid-access: all strobes are released the next clock, with no completion; reset dominates every other event.
- Start event:
  - ppi_cs is high and its registered copy is low (rising edge), and ioread|iowrite=1.
  - Direction is write if iowrite=1, else read; write wins if both are high.
  - An edge with neither qualifier is ignored.
- IDLE + start:
  - Latch address into ppi_a, cpu_dout into ppi_dout, and the direction.
  - Enter SETUP with counter=SETUP_CYC-1.
- SETUP: ppi_cs_n=0; ppi_doe=1 if write. When counter=0, go to STROBE with counter=STROBE_CYC-1; otherwise decrement.
- STROBE:
  - ppi_rd_n=0 (read) or ppi_wr_n=0 (write).
  - On the last STROBE cycle (counter=0), a read latches ppi_din into cpu_din.
  - Then go to HOLD with counter=HOLD_CYC-1.
- HOLD: strobe is high, ppi_cs_n=0, ppi_a/ppi_dout/ppi_doe unchanged. When counter=0, go to DONE.
- DONE: ppi_cs_n=1, ppi_doe=0. Stay in DONE while ppi_cs=1; when ppi_cs=0, go to RECOVER with counter=RECOV_CYC-1.
- RECOVER: all strobes inactive. When counter=0, go to IDLE, or straight to SETUP if pending=1 (pending is then cleared).
- pending:
  - Set by a start event occurring in RECOVER; direction and address are latched at the same time.
  - A start event in SETUP/STROBE/HOLD/DONE cannot occur because ppi_cs has not fallen.
- wait_req (combinational):
  - wait_req = (IDLE & start) | SETUP | STROBE | HOLD | pending | (RECOVER & start).
  - It is low in DONE, so the CPU completes its cycle.
- Latency with default parameters (start seen in cycle 0):
  - SETUP cycles 1-2, STROBE cycles 3-6, HOLD cycles 7-8, DONE at cycle 9.
  - wait_req is high for cycles 0-8.
  - Read data is valid on cpu_din from cycle 7 and holds until the next read latch.
- ppi_cs falls early (in SETUP/STROBE/HOLD): the sequence completes unchanged (no truncated strobe), then passes through DONE in one cycle to RECOVER.
- Counters are 4-bit; a parameter value of 0 is illegal (checked by a simulation assertion).

Test Plan:
- Read, defaults: address=2'b01, ioread=1, ppi_cs rises at cycle 0, ppi_din=0xA5 → ppi_cs_n low cycles 1-8; ppi_rd_n low cycles 3-6; cpu_din=0xA5 from cycle 7; wait_req high cycles 0-8, low at cycle 9.
- Write, defaults: address=2'b11, iowrite=1, cpu_dout=0x92 → ppi_wr_n low cycles 3-6; ppi_dout=0x92 and ppi_doe=1 cycles 1-8; ppi_a=3 throughout; ppi_rd_n stays 1.
- Back-to-back: second ppi_cs rising edge arrives 1 cycle after the first falls (in RECOVER) → pending=1 and wait_req high; second SETUP starts exactly RECOV_CYC clocks after RECOVER entry; ppi_cs_n high for at least 2 clocks between accesses.
- Early deassert: ppi_cs drops during STROBE → ppi_rd_n still low for the full 4 cycles; FSM goes HOLD→DONE→RECOVER→IDLE; busy=0 at cycle 12.
- Reset mid-strobe: reset=1 at cycle 4 of a write → at cycle 5 ppi_wr_n=1, ppi_cs_n=1, ppi_doe=0, wait_req=0, busy=0.
- Qualifier edge cases: ppi_cs rises with ioread=iowrite=0 → no strobe, wait_req=0. Both qualifiers high → write performed and ppi_rd_n never asserted. Parameters SETUP=1/STROBE=1/HOLD=1 → ppi_rd_n low exactly 1 cycle at cycle 2.
